multiexp_replay_feeder: RTL and testbench
=========================================

// Module: multiexp_replay_feeder
// PURPOSE
// - Sits directly upstream of multiexp_top; loads N {point, scalar} pairs once, then replays them NUM_PASS times.
// - multiexp_top consumes one full pass of all N pairs per scalar bit, so the host never re-streams data.
// - Buffers pairs in an internal RAM and presents the replay on an if_axi_stream master at up to 1 beat/clk.
// - Also drives o_num_in, the multiexp_top i_num_in.
// PARAMETERS
// - PNT_BITS   default 768  : width of one jb_point_t.
// - SCL_BITS   default 256  : width of one fe_t scalar.
// - MAX_IN     default 1024 : RAM depth; maximum pairs per job.
// - NUM_PASS   default 256  : replay passes; equals SCL_BITS in normal use.
// PORTS
// - i_clk            in   1                   : clock.
// - i_rst_n          in   1                   : synchronous reset, active-low.
// - i_start          in   1                   : 1-clk pulse; starts a job, latches i_num_in (honoured in IDLE only).
// - i_num_in         in   64                  : pair count N for the job.
// - i_pnt_scl_if     slv  (PNT+SCL+7)/8 byts  : load stream, dat = {point, scalar}; val/rdy/sop/eop used.
// - o_pnt_scl_if     mst  (PNT+SCL+7)/8 byts  : replay stream to multiexp_top; ctl[7:0] = pass index.
// - o_num_in         out  64                  : latched N.
// - o_busy           out  1                   : high outside IDLE.
// - o_err            out  1                   : sticky until next accepted i_start; bad N.
// BEHAVIOUR
// - Reset (i_rst_n=0 at a clk edge): state=IDLE.
//   - o_pnt_scl_if.val=0, i_pnt_scl_if.rdy=0.
//   - o_num_in=0, o_busy=0, o_err=0; all counters 0.
//   - RAM contents are don't-care.
// - IDLE: i_pnt_scl_if.rdy=0.
//   - i_start with 1<=N<=MAX_IN: latch N, o_err<=0, go LOAD next clk.
//   - i_start with N=0 or N>MAX_IN: o_err<=1, stay IDLE.
// - LOAD: i_pnt_scl_if.rdy=1.
//   - Each val&rdy beat writes RAM[wr_cnt]; wr_cnt increments.
//   - sop/eop on input are ignored; beat count alone ends the load.
//   - On beat N accepted: rdy drops the next clk, go REPLAY.
//   - i_start is ignored in LOAD.
// - REPLAY: emits RAM[0..N-1] in order, NUM_PASS times.
//   - pass counts 0..NUM_PASS-1.
//   - sop=1 on entry 0 of each pass; eop=1 on entry N-1 (N=1: sop=eop=1 on every beat).
//   - ctl[7:0] = pass[7:0]; mod=0; err=0.
//   - First val rises 2 clks after the last load beat (1-clk sync RAM read + output register).
// - Output handshake: standard AXI-S.
//   - Once val=1, dat/sop/eop/ctl hold stable until rdy=1.
//   - val never drops without a transfer.
//   - 2-entry skid/prefetch so full rate is sustained while rdy=1; rdy toggling loses/duplicates no beats.
//   - rd pointer wraps N-1 -> 0 and increments pass on wrap.
// - DONE: entered on transfer of last beat (pass NUM_PASS-1, entry N-1); val=0.
//   - Next clk -> IDLE; o_busy falls.
//   - RAM retained; a new i_start reloads from scratch.
// - Counters: wr/rd are clog2(MAX_IN+1) bits; pass is clog2(NUM_PASS+1) bits; no overflow for legal N.
// - i_start and last output transfer in the same clk: i_start ignored (not IDLE).
// - Reset mid-LOAD or mid-REPLAY:
//   - val/rdy low the following clk; no partial pass completes.
//   - The downstream core must be reset alongside.
// TESTING
// - N=16, 16 random pairs, out rdy=1 always:
//   - 4096 beats out, 256 sops/eops; beat k = pair k%16; ctl = k/16 (mod 256).
//   - Total cycles ≈ 16 + 2 + 4096.
// - N=1, NUM_PASS=4: 4 beats, each sop=eop=1, ctl 0,1,2,3; then o_busy=0.
// - N=MAX_IN=1024, out rdy random 50%: every beat of every pass matches scoreboard; val never drops without transfer; dat stable while stalled.
// - i_start with N=0, then N=1025: o_err=1, o_busy=0, load rdy stays 0.
//   - A following i_start with N=4 clears o_err and runs normally.
// - Reset (i_rst_n=0 for 1 clk) during pass 3 of an N=8 job:
//   - next clk out val=0, o_busy=0.
//   - New job N=2 then replays only the new data.
// - With multiexp_top: N=16 random pairs, NUM_PASS=256: affine result equals the software multiexp_batch reference.

Source files
------------

// File: rtl/multiexp_replay_feeder_if.sv
// Valid/ready beat stream between the replay feeder, its host loader and multiexp_top.
// dat carries {point, scalar}; ctl carries the pass index on the replay side.
interface multiexp_replay_feeder_if #(
  parameter int DAT_BYTS = 128,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [DAT_BYTS*8-1:0] dat;
  logic [CTL_BITS-1:0]   ctl;
  logic [MOD_BITS-1:0]   mod;

  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/multiexp_replay_feeder.sv
// Loads N {point, scalar} pairs into RAM once, then replays them NUM_PASS times
// towards multiexp_top, one pass per scalar bit, at up to one beat per clock.
module multiexp_replay_feeder #(
  parameter int PNT_BITS = 768,
  parameter int SCL_BITS = 256,
  parameter int MAX_IN   = 1024,
  parameter int NUM_PASS = 256
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic [63:0]                     i_num_in,
  multiexp_replay_feeder_if.slave         i_pnt_scl_if,
  multiexp_replay_feeder_if.master        o_pnt_scl_if,
  output logic [63:0]                     o_num_in,
  output logic                            o_busy,
  output logic                            o_err
);

  localparam int DAT_BYTS = (PNT_BITS + SCL_BITS + 7) / 8;
  localparam int DAT_W    = DAT_BYTS * 8;
  localparam int CW       = $clog2(MAX_IN + 1);
  localparam int AW       = $clog2(MAX_IN);
  localparam int PW       = $clog2(NUM_PASS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, REPLAY, DONE} state_t;

  typedef struct packed {
    logic [DAT_W-1:0] dat;
    logic             sop;
    logic             eop;
    logic             last;
    logic [7:0]       ctl;
  } beat_t;

  function automatic logic [7:0] ctl_of(input logic [PW-1:0] pass);
    logic [PW+7:0] wide;
    wide = {8'd0, pass};
    return wide[7:0];
  endfunction

  state_t           state, state_nxt;
  logic [63:0]      num_reg;
  logic             err_q;
  logic [CW-1:0]    n_cnt;
  logic [CW-1:0]    wr_cnt;
  logic [CW-1:0]    rd_ptr;
  logic [PW-1:0]    pass_cnt;
  logic             rd_left;
  logic [DAT_W-1:0] ram [MAX_IN];

  logic             rd_vld_p1;
  beat_t            beat_p1;
  logic [1:0]       buf_cnt_p2;
  beat_t            head_p2;
  beat_t            skid_p2;

  logic             num_ok;
  logic             start_ok;
  logic             load_beat;
  logic             last_load;
  logic             pop;
  logic             rd_ptr_last;
  logic             pass_last;
  logic [2:0]       occ;
  logic             issue;

  assign n_cnt       = num_reg[CW-1:0];
  assign num_ok      = (i_num_in != 64'd0) && (i_num_in <= 64'(MAX_IN));
  assign start_ok    = (state == IDLE) && i_start && num_ok;
  assign load_beat   = (state == LOAD) && i_pnt_scl_if.val;
  assign last_load   = load_beat && (wr_cnt == n_cnt - CW'(1));
  assign pop         = (buf_cnt_p2 != 2'd0) && o_pnt_scl_if.rdy;
  assign rd_ptr_last = (rd_ptr == n_cnt - CW'(1));
  assign pass_last   = (pass_cnt == PW'(NUM_PASS - 1));

  // Fetch only when the RAM result is guaranteed a slot in the 2-entry buffer.
  assign occ   = {1'b0, buf_cnt_p2} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign issue = (state == REPLAY) && rd_left && (occ < 3'd2);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = LOAD;
      LOAD:    if (last_load) state_nxt = REPLAY;
      REPLAY:  if (pop && head_p2.last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      num_reg    <= 64'd0;
      err_q      <= 1'b0;
      wr_cnt     <= '0;
      rd_ptr     <= '0;
      pass_cnt   <= '0;
      rd_left    <= 1'b0;
      rd_vld_p1  <= 1'b0;
      buf_cnt_p2 <= 2'd0;
    end else begin
      if ((state == IDLE) && i_start) begin
        if (num_ok) begin
          num_reg  <= i_num_in;
          err_q    <= 1'b0;
          wr_cnt   <= '0;
          rd_ptr   <= '0;
          pass_cnt <= '0;
          rd_left  <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (load_beat) wr_cnt <= wr_cnt + CW'(1);
      if (issue) begin
        if (rd_ptr_last) begin
          rd_ptr <= '0;
          if (pass_last) rd_left  <= 1'b0;
          else           pass_cnt <= pass_cnt + PW'(1);
        end else begin
          rd_ptr <= rd_ptr + CW'(1);
        end
      end
      rd_vld_p1  <= issue;
      buf_cnt_p2 <= buf_cnt_p2 + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

  // Stage p1: synchronous RAM read, tagged with framing and pass index.
  always_ff @(posedge i_clk) begin
    if (load_beat) ram[wr_cnt[AW-1:0]] <= i_pnt_scl_if.dat;
    if (issue) begin
      beat_p1.dat  <= ram[rd_ptr[AW-1:0]];
      beat_p1.sop  <= (rd_ptr == '0);
      beat_p1.eop  <= rd_ptr_last;
      beat_p1.last <= rd_ptr_last && pass_last;
      beat_p1.ctl  <= ctl_of(pass_cnt);
    end
  end

  // Stage p2: head register drives the port; skid absorbs the in-flight read on stall.
  always_ff @(posedge i_clk) begin
    if ((buf_cnt_p2 == 2'd0) || ((buf_cnt_p2 == 2'd1) && pop)) begin
      if (rd_vld_p1) head_p2 <= beat_p1;
    end else if ((buf_cnt_p2 == 2'd2) && pop) begin
      head_p2 <= skid_p2;
    end
    if (rd_vld_p1 && (((buf_cnt_p2 == 2'd1) && !pop) || ((buf_cnt_p2 == 2'd2) && pop)))
      skid_p2 <= beat_p1;
  end

  assign o_pnt_scl_if.val = (buf_cnt_p2 != 2'd0);
  assign o_pnt_scl_if.dat = head_p2.dat;
  assign o_pnt_scl_if.sop = head_p2.sop;
  assign o_pnt_scl_if.eop = head_p2.eop;
  assign o_pnt_scl_if.ctl = head_p2.ctl;
  assign o_pnt_scl_if.mod = '0;
  assign o_pnt_scl_if.err = 1'b0;

  assign i_pnt_scl_if.rdy = (state == LOAD);
  assign o_num_in         = num_reg;
  assign o_busy           = (state != IDLE);
  assign o_err            = err_q;

  logic unused_in;
  assign unused_in = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop, i_pnt_scl_if.err,
                       i_pnt_scl_if.ctl, i_pnt_scl_if.mod};

endmodule

// File: tb/tb_multiexp_replay_feeder.sv
// Scoreboard bench for multiexp_replay_feeder on a small configuration:
// 32-bit pairs, MAX_IN=16, NUM_PASS=4.
module tb_multiexp_replay_feeder;

  localparam int PNT_BITS = 24;
  localparam int SCL_BITS = 8;
  localparam int MAX_IN   = 16;
  localparam int NUM_PASS = 4;
  localparam int DAT_BYTS = (PNT_BITS + SCL_BITS + 7) / 8;

  typedef struct packed {
    logic [31:0] dat;
    logic        sop;
    logic        eop;
    logic [7:0]  ctl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] num;
  logic [63:0] num_out;
  logic        busy;
  logic        err;

  multiexp_replay_feeder_if #(.DAT_BYTS(DAT_BYTS)) in_if ();
  multiexp_replay_feeder_if #(.DAT_BYTS(DAT_BYTS)) out_if ();

  multiexp_replay_feeder #(
    .PNT_BITS(PNT_BITS), .SCL_BITS(SCL_BITS), .MAX_IN(MAX_IN), .NUM_PASS(NUM_PASS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_in(num),
    .i_pnt_scl_if(in_if), .o_pnt_scl_if(out_if),
    .o_num_in(num_out), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   rdy_mode = 1;
  logic prev_stall = 1'b0;
  exp_t prev_beat;

  function automatic logic [31:0] pat(input int j, input int k);
    return 32'(j) * 32'h0100_0000 + 32'(k) * 32'h0001_0203 + 32'h0000_005A;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_if.rdy = 1'b0;
      1:       out_if.rdy = 1'b1;
      default: out_if.rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    got.dat = out_if.dat;
    got.sop = out_if.sop;
    got.eop = out_if.eop;
    got.ctl = out_if.ctl;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!out_if.val || got != prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got val=%0b beat=%h, required val=1 beat=%h",
                   out_if.val, got, prev_beat);
        end
      end
      if (out_if.val && out_if.rdy) begin
        checks++;
        beats++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got beat=%h, required no beat", got);
        end else begin
          e = sb.pop_front();
          if (got != e) begin
            errors++;
            $display("FAIL beat: got dat=%h sop=%0b eop=%0b ctl=%0d, required dat=%h sop=%0b eop=%0b ctl=%0d",
                     got.dat, got.sop, got.eop, got.ctl, e.dat, e.sop, e.eop, e.ctl);
          end
        end
      end
      prev_stall = out_if.val && !out_if.rdy;
      prev_beat  = got;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push_expected(input int job, input int n);
    exp_t e;
    for (int p = 0; p < NUM_PASS; p++) begin
      for (int k = 0; k < n; k++) begin
        e.dat = pat(job, k);
        e.sop = (k == 0);
        e.eop = (k == n - 1);
        e.ctl = 8'(p);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_job(input logic [63:0] n);
    start = 1'b1;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input int job, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      if (k == 3) begin
        in_if.val = 1'b0;
        tick();
      end
      in_if.val = 1'b1;
      in_if.dat = pat(job, k);
      in_if.sop = (k == 0);
      in_if.eop = (k == n - 1);
      t = 0;
      while (!in_if.rdy && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) begin
        checks++;
        errors++;
        $display("FAIL load_rdy_timeout: got rdy=0, required rdy=1 at beat %0d", k);
      end
      tick();
    end
    in_if.val = 1'b0;
    in_if.sop = 1'b0;
    in_if.eop = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (busy && t < bound) begin
      tick();
      t++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_job(input int job, input int n, input int bound);
    beats = 0;
    push_expected(job, n);
    start_job(64'(n));
    load(job, n);
    wait_idle(bound);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("beat_count", 64'(beats), 64'(n * NUM_PASS));
  endtask

  initial begin
    int t;
    rst_n     = 1'b0;
    start     = 1'b0;
    num       = 64'd0;
    in_if.val = 1'b0;
    in_if.dat = '0;
    in_if.sop = 1'b0;
    in_if.eop = 1'b0;
    in_if.err = 1'b0;
    in_if.ctl = '0;
    in_if.mod = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_val", 64'(out_if.val), 64'd0);
    chk("rst_load_rdy", 64'(in_if.rdy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_num_in", num_out, 64'd0);
    rst_n = 1'b1;
    tick();

    run_job(1, 16, 400);

    run_job(2, 1, 100);
    chk("n1_busy_after", 64'(busy), 64'd0);

    rdy_mode = 2;
    run_job(3, MAX_IN, 1000);
    rdy_mode = 1;

    start_job(64'd0);
    chk("n0_err", 64'(err), 64'd1);
    chk("n0_busy", 64'(busy), 64'd0);
    tick();
    chk("n0_load_rdy", 64'(in_if.rdy), 64'd0);
    start_job(64'(MAX_IN + 1));
    chk("nbig_err", 64'(err), 64'd1);
    chk("nbig_busy", 64'(busy), 64'd0);
    tick();
    chk("nbig_load_rdy", 64'(in_if.rdy), 64'd0);

    beats = 0;
    push_expected(4, 4);
    start_job(64'd4);
    chk("n4_err_clear", 64'(err), 64'd0);
    chk("n4_busy", 64'(busy), 64'd1);
    chk("n4_num_in", num_out, 64'd4);
    load(4, 4);
    wait_idle(200);
    chk("n4_sb_empty", 64'(sb.size()), 64'd0);
    chk("n4_beat_count", 64'(beats), 64'd16);

    beats = 0;
    push_expected(5, 8);
    start_job(64'd8);
    load(5, 8);
    t = 0;
    while (beats < 26 && t < 200) begin
      tick();
      t++;
    end
    chk("pass3_reached", 64'(beats >= 26), 64'd1);
    rdy_mode = 0;
    tick();
    rst_n = 1'b0;
    sb.delete();
    tick();
    chk("midrst_val", 64'(out_if.val), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    rdy_mode = 1;
    tick();

    run_job(6, 2, 100);
    chk("n2_num_in", num_out, 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
